// File: rtl/speaker_pcm_filter_if.sv
// PCM sample stream between the speaker filter and the audio mixer.
// The filter drives the sample and its valid flag; the mixer returns ready.
interface speaker_pcm_filter_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] sample_o;
    logic                         sample_valid_o;
    logic                         sample_ready_i;

    modport master (
        output sample_o,
        output sample_valid_o,
        input  sample_ready_i
    );

    modport slave (
        input  sample_o,
        input  sample_valid_o,
        output sample_ready_i
    );
endinterface

// File: rtl/speaker_pcm_filter.sv
// Apple II speaker level -> band-limited signed PCM: two-flop synchronizer,
// per-clock one-pole IIR low-pass, decimation on sample_tick_i into a 1-deep output register.
module speaker_pcm_filter #(
    parameter int                           DATA_WIDTH   = 16,
    parameter logic signed [DATA_WIDTH-1:0] AMPLITUDE    = 16'sh1FFF,
    parameter int                           FRAC_BITS    = 8,
    parameter int                           FILTER_SHIFT = 8
) (
    input  logic                    clk_logic,
    input  logic                    system_reset,
    input  logic                    enable,
    input  logic                    speaker_i,
    input  logic                    sample_tick_i,
    speaker_pcm_filter_if.master    pcm,
    output logic                    overrun_o,
    input  logic                    clear_overrun_i
);

    localparam int AW = DATA_WIDTH + FRAC_BITS;
    localparam int XW = AW + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic                         s1_q;
    logic                         s2_q;
    logic signed [AW-1:0]         acc_q;
    logic signed [AW-1:0]         acc_d;
    logic signed [XW-1:0]         target;
    logic signed [XW-1:0]         acc_wide;
    logic signed [XW-1:0]         diff;
    logic signed [XW-1:0]         step;
    logic signed [DATA_WIDTH-1:0] sample_q;
    logic signed [DATA_WIDTH-1:0] sample_d;
    state_t                       state_q;
    state_t                       state_d;
    logic                         overrun_q;
    logic                         overrun_d;
    logic                         load;
    logic                         ovr_set;

    // Filter: diff is one bit wider than acc so the subtraction never wraps.
    always_comb begin
        target = '0;
        if (enable && s2_q) begin
            target = XW'(AMPLITUDE) <<< FRAC_BITS;
        end
        acc_wide = XW'(acc_q);
        diff     = target - acc_wide;
        step     = diff >>> FILTER_SHIFT;
        // Nudge by one LSB once the scaled step vanishes so acc lands exactly on target.
        if (step == '0 && diff != '0) begin
            step = diff[AW] ? '1 : XW'(1);
        end
        acc_d = acc_q + step[AW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        load     = 1'b0;
        ovr_set  = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (sample_tick_i) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (sample_tick_i) begin
                    if (pcm.sample_ready_i) begin
                        load = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end else if (pcm.sample_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            sample_d = acc_q[AW-1:FRAC_BITS];
        end
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            acc_q     <= '0;
            sample_q  <= '0;
            state_q   <= EMPTY;
            overrun_q <= 1'b0;
        end else begin
            s1_q      <= speaker_i;
            s2_q      <= s1_q;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign pcm.sample_o       = sample_q;
    assign pcm.sample_valid_o = (state_q == FULL);
    assign overrun_o          = overrun_q;

endmodule
